// File: rtl/llki_pkg.sv
// Shared constants and types for the LLKI mask unit: default expected key
// and the key-loader state encoding.
package llki_pkg;

   localparam int LLKI_MASK_UNIT_NUM_KEY_WORDS = 2;

   localparam logic [63:0] LLKI_MASK_UNIT_KEY_WORDS [LLKI_MASK_UNIT_NUM_KEY_WORDS] = '{
      64'h0123456789ABCDEF,
      64'hFEDCBA9876543210
   };

   // Word i of the expected key sits at bits [64*i+63:64*i].
   localparam logic [64*LLKI_MASK_UNIT_NUM_KEY_WORDS-1:0] LLKI_MASK_UNIT_EXPECTED_KEY = {
      LLKI_MASK_UNIT_KEY_WORDS[1],
      LLKI_MASK_UNIT_KEY_WORDS[0]
   };

   typedef enum logic [1:0] {
      LDR_IDLE     = 2'd0,
      LDR_LOAD     = 2'd1,
      LDR_COMPLETE = 2'd2
   } llki_loader_state_t;

endpackage

// File: rtl/llki_key_loader.sv
// LLKI key loader: accepts KEY_WORDS 64-bit words over a valid/ready handshake,
// holds them in the key register and handles zeroize with a registered ack.
module llki_key_loader
   import llki_pkg::*;
#(
   parameter int KEY_WORDS = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [63:0]             key_data_i,
   input  logic                    key_valid_i,
   input  logic                    clear_i,
   output logic [64*KEY_WORDS-1:0] key_o,
   output logic                    ready_o,
   output logic                    complete_o,
   output logic                    ack_o
);

   localparam int CNT_W = $clog2(KEY_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_WORDS - 1);

   llki_loader_state_t      state_d, state_q;
   logic [CNT_W-1:0]        cnt_d, cnt_q;
   logic [64*KEY_WORDS-1:0] key_d, key_q;
   logic                    ready_d, ready_q;
   logic                    complete_d, complete_q;
   logic                    ack_d, ack_q;

   // Clear wins over a simultaneous transfer, so the word on the bus is dropped.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_d      = key_q;
      ready_d    = ready_q;
      complete_d = complete_q;
      ack_d      = clear_i;
      if (clear_i) begin
         state_d    = LDR_IDLE;
         cnt_d      = '0;
         key_d      = '0;
         ready_d    = 1'b1;
         complete_d = 1'b0;
      end else begin
         case (state_q)
            LDR_IDLE, LDR_LOAD: begin
               if (key_valid_i && ready_q) begin
                  for (int i = 0; i < KEY_WORDS; i++) begin
                     if (cnt_q == CNT_W'(i)) begin
                        key_d[i*64 +: 64] = key_data_i;
                     end else begin
                        key_d[i*64 +: 64] = key_q[i*64 +: 64];
                     end
                  end
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) begin
                     state_d    = LDR_COMPLETE;
                     ready_d    = 1'b0;
                     complete_d = 1'b1;
                  end else begin
                     state_d = LDR_LOAD;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            LDR_COMPLETE: begin
               state_d = LDR_COMPLETE;
            end
            default: begin
               state_d    = LDR_IDLE;
               cnt_d      = '0;
               key_d      = '0;
               ready_d    = 1'b1;
               complete_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= LDR_IDLE;
         cnt_q      <= '0;
         key_q      <= '0;
         ready_q    <= 1'b1;
         complete_q <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         ready_q    <= ready_d;
         complete_q <= complete_d;
         ack_q      <= ack_d;
      end
   end

   assign key_o      = key_q;
   assign ready_o    = ready_q;
   assign complete_o = complete_q;
   assign ack_o      = ack_q;

endmodule

// File: rtl/llki_tss_mask_unit.sv
// LLKI-keyed multi-channel data mask: each channel is XORed with a slice of
// (expected key ^ loaded key), optionally rotated per beat, through a register.
module llki_tss_mask_unit
   import llki_pkg::*;
#(
   parameter int                      KEY_WORDS    = LLKI_MASK_UNIT_NUM_KEY_WORDS,
   parameter int                      NUM_CH       = 4,
   parameter int                      DATA_W       = 32,
   parameter logic [64*KEY_WORDS-1:0] EXPECTED_KEY = LLKI_MASK_UNIT_EXPECTED_KEY,
   parameter bit                      ROLL_MASK    = 1'b0,
   parameter bit                      LOCK_GATE    = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [63:0]              llkid_key_data,
   input  logic                     llkid_key_valid,
   output logic                     llkid_key_ready,
   output logic                     llkid_key_complete,
   input  logic                     llkid_clear_key,
   output logic                     llkid_clear_key_ack,
   input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
   input  logic [NUM_CH-1:0]        ch_in_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_out_data,
   output logic [NUM_CH-1:0]        ch_out_valid
);

   localparam int KEY_W      = 64 * KEY_WORDS;
   localparam int NUM_SLICES = KEY_W / DATA_W;
   localparam int RW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [KEY_W-1:0] key_s;
   logic [KEY_W-1:0] mask_s;
   logic             complete_s;

   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v, input logic [RW-1:0] n);
      logic [2*DATA_W-1:0] dbl;
      dbl = {v, v} << n;
      return dbl[2*DATA_W-1 -: DATA_W];
   endfunction

   llki_key_loader #(
      .KEY_WORDS (KEY_WORDS)
   ) u_loader (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_data_i (llkid_key_data),
      .key_valid_i(llkid_key_valid),
      .clear_i    (llkid_clear_key),
      .key_o      (key_s),
      .ready_o    (llkid_key_ready),
      .complete_o (complete_s),
      .ack_o      (llkid_clear_key_ack)
   );

   assign llkid_key_complete = complete_s;
   assign mask_s             = EXPECTED_KEY ^ key_s;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int SLICE = c % NUM_SLICES;

      logic [DATA_W-1:0] base_s, chan_mask_s, data_d, data_q;
      logic [RW-1:0]     roll_d, roll_q;
      logic              valid_d, valid_q;

      assign base_s = mask_s[SLICE*DATA_W +: DATA_W];

      // The beat uses the current roll offset; the counter advances afterwards.
      always_comb begin
         chan_mask_s = ROLL_MASK ? rotl(base_s, roll_q) : base_s;
         data_d      = data_q;
         roll_d      = roll_q;
         valid_d     = ch_in_valid[c] & (LOCK_GATE ? complete_s : 1'b1);
         if (ch_in_valid[c]) begin
            data_d = ch_in_data[c*DATA_W +: DATA_W] ^ chan_mask_s;
         end else begin
            data_d = data_q;
         end
         if (llkid_clear_key) begin
            roll_d = '0;
         end else if (ch_in_valid[c]) begin
            roll_d = (roll_q == RW'(DATA_W - 1)) ? '0 : roll_q + RW'(1);
         end else begin
            roll_d = roll_q;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q  <= '0;
            roll_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            roll_q  <= roll_d;
            valid_q <= valid_d;
         end
      end

      assign ch_out_data[c*DATA_W +: DATA_W] = data_q;
      assign ch_out_valid[c]                 = valid_q;
   end

endmodule

// File: doc/llki_tss_mask_unit.md
# llki_tss_mask_unit

Parametrised LLKI-keyed data-masking unit, the multi-channel successor to the single-core mock TSS wrapper. It loads a KEY_WORDS×64-bit key over the LLKI discrete handshake and XORs each of NUM_CH data channels with a per-channel slice of (expected key ⊕ loaded key). It sits between a bus-facing register/memory write path and the protected core. With the correct key loaded, data passes through unchanged; otherwise it is garbled. New relative to the previous generation: channel count, data width and key depth are parameters; the mask can optionally roll per beat; the output can be gated until the key is loaded; and the output stage is registered.

## Interface
- KEY_WORDS, 2: number of 64-bit key words; must be ≥1.
- NUM_CH, 4: number of masked data channels; must be ≥1.
- DATA_W, 32: channel width; must be ≤64, and 64*KEY_WORDS must be a multiple of DATA_W.
- EXPECTED_KEY, llki_pkg constant: 64*KEY_WORDS-bit expected key; word i occupies bits [64*i+63:64*i].
- ROLL_MASK, 0: 1 = per-channel mask rotates left by one bit per accepted beat.
- LOCK_GATE, 0: 1 = ch_out_valid is suppressed while llkid_key_complete is 0.

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- llkid_key_data  in  64  key word.
- llkid_key_valid  in  1  key word valid.
- llkid_key_ready  out  1  unit accepts a key word.
- llkid_key_complete  out  1  all KEY_WORDS words loaded.
- llkid_clear_key  in  1  zeroize request.
- llkid_clear_key_ack  out  1  zeroize acknowledge.
- ch_in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- ch_in_valid  in  NUM_CH  per-channel beat valid.
- ch_out_data  out  NUM_CH*DATA_W  masked data, registered.
- ch_out_valid  out  NUM_CH  registered valid.

## Operation
- Loader FSM states:
  - IDLE (word count 0, ready=1).
  - LOAD (0 < word count < KEY_WORDS, ready=1).
  - COMPLETE (ready=0, complete=1).
- Transfer occurs when llkid_key_valid and llkid_key_ready are both high. The word is written to key slot [word count], then the count increments.
- Accepting word KEY_WORDS-1 moves the FSM to COMPLETE.
- In COMPLETE, key_valid is ignored. Complete stays high until a clear or reset.
- Clear, sampled high in any state:
  - Key register, word count, complete and all roll counters go to 0; state goes to IDLE.
  - llkid_clear_key_ack is high in the following cycle. The ack is a registered copy of clear, so holding clear for N cycles gives N ack cycles.
  - Clear has priority over a simultaneous key transfer; that word is discarded.
- Effective mask M = EXPECTED_KEY ⊕ key register.
- Channel c base mask = M[(c mod S)*DATA_W +: DATA_W], where S = 64*KEY_WORDS/DATA_W. Channel indices wrap around the available slices.
- ROLL_MASK=1:
  - Each channel has a counter r_c in 0..DATA_W-1; the applied mask is rotl(base mask, r_c).
  - r_c increments, wrapping at DATA_W, on every cycle ch_in_valid[c] is high, after that beat's mask is applied.
  - r_c is unaffected by key loading; it is cleared only by reset or clear.
- ROLL_MASK=0: the mask is the base mask.
- Output: ch_out_data[c] ← ch_in_data[c] ⊕ mask_c; ch_out_valid[c] ← ch_in_valid[c] & (LOCK_GATE ? complete : 1).
- ch_out_data updates only when ch_in_valid[c] is high; otherwise it holds its value.

## Timing
- Reset values: llkid_key_ready=1, llkid_key_complete=0, llkid_clear_key_ack=0, ch_out_data=0, ch_out_valid=0. Key register=0, so M=EXPECTED_KEY and data is garbled.
- Data latency: 1 cycle, from ch_in sampled at edge N to ch_out visible after edge N.
- The mask applied at edge N uses the key register value before edge N. A key word accepted at edge N affects beats sampled from edge N+1 onward.
- llkid_key_complete rises the cycle after the last word is accepted; llkid_key_ready falls in the same cycle.
- Reset asserted mid-load or mid-stream: all state is cleared immediately and asynchronously.

## Structure
- llki_pkg holds:
  - LLKI_MASK_UNIT_NUM_KEY_WORDS.
  - The LLKI_MASK_UNIT_KEY_WORDS expected-key array.
  - The loader state enum typedef llki_loader_state_t.
- One sub-module, llki_key_loader (parameter KEY_WORDS): the loader FSM, word counter, key register and clear/ack logic; it outputs key register, ready, complete and ack.
- Masking, roll counters and the output register live in the top module, in a generate loop over NUM_CH.

## Test plan
Defaults: KEY_WORDS=2, NUM_CH=4, DATA_W=32, EXPECTED word0=0x0123456789ABCDEF, word1=0xFEDCBA9876543210.

1. After reset with no key, ch0 input 0x00000000 valid → ch0 output 0x89ABCDEF one cycle later; ch1 output 0x01234567; ready=1, complete=0.
2. Load both correct words back-to-back, then ch2 input 0xDEADBEEF → complete=1 and ready=0 the cycle after the second accept; ch2 output 0xDEADBEEF. A third key_valid is ignored.
3. Load word0 = expected ⊕ 0x1 plus the correct word1, then ch0 input 0x00000010 → ch0 output 0x00000011; ch2 is unaffected.
4. Accept one word, then assert clear for one cycle alongside key_valid → ack high for exactly 1 cycle, the word is discarded, ready=1, count=0. A subsequent correct 2-word load passes data through unmasked.
5. ROLL_MASK=1, no key, three ch0 beats of 0 → outputs 0x89ABCDEF, 0x13579BDF, 0x26AF37BE. After 32 beats the mask returns to 0x89ABCDEF.
6. LOCK_GATE=1: ch3 beats before complete → ch_out_valid[3] stays 0. After a correct load, the next beat gives ch_out_valid[3]=1. Reset_n pulsed mid-stream → all outputs 0 immediately.
